// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared constants and timer state encoding for data_mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] OFF_GPIO  = 2'd0;
    localparam logic [1:0] OFF_TCNT  = 2'd1;
    localparam logic [1:0] OFF_TCMP  = 2'd2;
    localparam logic [1:0] OFF_TCTRL = 2'd3;

    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_AUTO  = 1;
    localparam int TCTRL_MATCH = 8;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_DONE  = 2'd2
    } tstate_e;

endpackage

`default_nettype wire

// File: rtl/dmem_timer.sv
// ============================================================================
// Module  : dmem_timer
// Brief   : Compare timer (TCNT/TCMP/TCTRL) with one-shot/auto-reload FSM and
//           sticky MATCH flag driven from decoded MMIO write strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_timer
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_tcnt_i,
    input  logic              we_tcmp_i,
    input  logic              we_tctrl_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] tcnt_o,
    output logic [DATA_W-1:0] tcmp_o,
    output logic [DATA_W-1:0] tctrl_o,
    output logic              irq_o
);

    tstate_e           state_q;
    logic [DATA_W-1:0] tcnt_q;
    logic [DATA_W-1:0] tcmp_q;
    logic              en_q;
    logic              auto_q;
    logic              match_q;

    logic w_hit;
    logic w_disable;
    logic w_enable;
    logic w_set;

    assign w_hit     = (state_q == T_COUNT) && (tcnt_q == tcmp_q);
    assign w_disable = we_tctrl_i && !wdata_i[TCTRL_EN];
    assign w_enable  = we_tctrl_i &&  wdata_i[TCTRL_EN];
    // A counter load or a disable in the match cycle pre-empts the match.
    assign w_set     = w_hit && !we_tcnt_i && !w_disable;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= T_IDLE;
            tcnt_q  <= '0;
            tcmp_q  <= '1;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            if (we_tcmp_i) begin
                tcmp_q <= wdata_i;
            end
            if (we_tctrl_i) begin
                en_q   <= wdata_i[TCTRL_EN];
                auto_q <= wdata_i[TCTRL_AUTO];
            end
            if (w_set) begin
                match_q <= 1'b1;
            end else if (we_tctrl_i && wdata_i[TCTRL_MATCH]) begin
                match_q <= 1'b0;
            end

            case (state_q)
                T_IDLE: begin
                    if (we_tcnt_i) begin
                        tcnt_q <= wdata_i;
                    end
                    if (w_enable) begin
                        state_q <= T_COUNT;
                    end
                end
                T_COUNT: begin
                    if (w_disable) begin
                        state_q <= T_IDLE;
                    end else if (we_tcnt_i) begin
                        tcnt_q <= wdata_i;
                    end else if (w_hit) begin
                        if (auto_q) begin
                            tcnt_q <= '0;
                        end else begin
                            state_q <= T_DONE;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                T_DONE: begin
                    if (w_disable) begin
                        state_q <= T_IDLE;
                    end else if (we_tcnt_i) begin
                        tcnt_q  <= wdata_i;
                        state_q <= T_COUNT;
                    end else if (w_enable) begin
                        state_q <= T_COUNT;
                    end
                end
                default: begin
                    state_q <= T_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tctrl_o              = '0;
        tctrl_o[TCTRL_EN]    = en_q;
        tctrl_o[TCTRL_AUTO]  = auto_q;
        tctrl_o[TCTRL_MATCH] = match_q;
    end

    assign tcnt_o = tcnt_q;
    assign tcmp_o = tcmp_q;
    assign irq_o  = match_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : Word-addressed data RAM plus MMIO window (GPIO, optional timer
//           when DMEM_TIMER_EN is defined) with sticky unmapped-access flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] memAddr_i,
    input  logic [DATA_W-1:0] memData_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    output logic [DATA_W-1:0] memData_o,
    output logic [DATA_W-1:0] gpio_o,
    output logic              timerIrq_o,
    output logic              err_o
);

    localparam int RAM_IDX_W = $clog2(RAM_DEPTH);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] gpio_q;
    logic [DATA_W-1:0] gpio_d;
    logic              err_q;
    logic              err_d;

    logic                 w_ram_hit;
    logic                 w_mmio_hit;
    logic [1:0]           w_off;
    logic                 w_sel_gpio;
    logic                 w_mapped;
    logic [RAM_IDX_W-1:0] w_ram_idx;
    logic [DATA_W-1:0]    w_rdata;

    assign w_ram_hit  = (memAddr_i < ADDR_W'(RAM_DEPTH));
    assign w_mmio_hit = (memAddr_i[ADDR_W-1:2] == MMIO_BASE[ADDR_W-1:2]);
    assign w_off      = memAddr_i[1:0];
    assign w_sel_gpio = w_mmio_hit && (w_off == OFF_GPIO);
    assign w_ram_idx  = memAddr_i[RAM_IDX_W-1:0];

`ifdef DMEM_TIMER_EN
    logic              w_sel_tcnt;
    logic              w_sel_tcmp;
    logic              w_sel_tctrl;
    logic [DATA_W-1:0] w_tcnt;
    logic [DATA_W-1:0] w_tcmp;
    logic [DATA_W-1:0] w_tctrl;

    assign w_sel_tcnt  = w_mmio_hit && (w_off == OFF_TCNT);
    assign w_sel_tcmp  = w_mmio_hit && (w_off == OFF_TCMP);
    assign w_sel_tctrl = w_mmio_hit && (w_off == OFF_TCTRL);
    assign w_mapped    = w_ram_hit || w_mmio_hit;

    dmem_timer #(
        .DATA_W (DATA_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_tcnt_i  (memWrite_i && w_sel_tcnt),
        .we_tcmp_i  (memWrite_i && w_sel_tcmp),
        .we_tctrl_i (memWrite_i && w_sel_tctrl),
        .wdata_i    (memData_i),
        .tcnt_o     (w_tcnt),
        .tcmp_o     (w_tcmp),
        .tctrl_o    (w_tctrl),
        .irq_o      (timerIrq_o)
    );
`else
    logic [1:0] w_unused_offs;

    assign w_unused_offs = OFF_TCNT ^ OFF_TCMP ^ OFF_TCTRL;
    assign w_mapped      = w_ram_hit || w_sel_gpio;
    assign timerIrq_o    = 1'b0;
`endif

    // Load path reads current register state, so a load+store pair sees
    // the pre-store value.
    always_comb begin
        w_rdata = '0;
        if (memRead_i) begin
            if (w_ram_hit) begin
                w_rdata = mem_q[w_ram_idx];
            end else if (w_sel_gpio) begin
                w_rdata = gpio_q;
`ifdef DMEM_TIMER_EN
            end else if (w_sel_tcnt) begin
                w_rdata = w_tcnt;
            end else if (w_sel_tcmp) begin
                w_rdata = w_tcmp;
            end else if (w_sel_tctrl) begin
                w_rdata = w_tctrl;
`endif
            end
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (memWrite_i && w_sel_gpio) begin
            gpio_d = memData_i;
        end
        err_d = err_q || ((memRead_i || memWrite_i) && !w_mapped);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gpio_q <= '0;
            err_q  <= 1'b0;
        end else begin
            gpio_q <= gpio_d;
            err_q  <= err_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (memWrite_i && w_ram_hit) begin
            mem_q[w_ram_idx] <= memData_i;
        end
    end

    assign memData_o = w_rdata;
    assign gpio_o    = gpio_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire
